ofs_plat_host_chan_rx_c0_merge: RTL

Parametrised merge stage for the CCI-P sRx.c0 channel. It combines host MMIO requests (no flow control) with N independent read-response streams into one registered c0 output. It replaces the fixed two-source, MMIO-always-wins merge used in the TLP-to-CCI-P mapping. It adds:
- buffering of MMIO requests;
- round-robin arbitration across read-response channels;
- an optional bound on MMIO starvation of read responses.

---
 rtl/ofs_plat_host_chan_rx_c0_merge_if.sv | 53 +++++
 rtl/ofs_plat_host_chan_rx_c0_merge.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_host_chan_rx_c0_merge_if.sv
// rtl/ofs_plat_host_chan_rx_c0_merge_if.sv - c0 merge bus: MMIO input, read-response inputs, registered c0 output
//
// Purpose: bundles every non-clock signal of the c0 merge stage.
// Modports:
//   master - environment side: drives MMIO requests and read-response
//            streams, observes rsp_ready, the c0 output and mmio_overflow.
//   slave  - merge stage side: the mirror image of master.
// Signals:
//   mmio_valid/mmio_is_write/mmio_hdr/mmio_data  MMIO request, no flow control
//   rsp_valid/rsp_ready/rsp_hdr/rsp_data         per-channel responses,
//                                                channel i at [i*W +: W]
//   c0_rspValid/c0_mmioRdValid/c0_mmioWrValid    registered, mutually exclusive
//   c0_hdr/c0_data/c0_src                        registered beat contents
//   mmio_overflow                                sticky MMIO drop flag
interface ofs_plat_host_chan_rx_c0_merge_if #(
  parameter int N_RSP_CHANNELS = 2,
  parameter int DATA_WIDTH = 512,
  parameter int HDR_WIDTH = 28
);
  localparam int SRC_WIDTH = (N_RSP_CHANNELS > 1) ? $clog2(N_RSP_CHANNELS) : 1;

  logic                                 mmio_valid;
  logic                                 mmio_is_write;
  logic [HDR_WIDTH-1:0]                 mmio_hdr;
  logic [DATA_WIDTH-1:0]                mmio_data;
  logic [N_RSP_CHANNELS-1:0]            rsp_valid;
  logic [N_RSP_CHANNELS-1:0]            rsp_ready;
  logic [N_RSP_CHANNELS*HDR_WIDTH-1:0]  rsp_hdr;
  logic [N_RSP_CHANNELS*DATA_WIDTH-1:0] rsp_data;
  logic                                 c0_rspValid;
  logic                                 c0_mmioRdValid;
  logic                                 c0_mmioWrValid;
  logic [HDR_WIDTH-1:0]                 c0_hdr;
  logic [DATA_WIDTH-1:0]                c0_data;
  logic [SRC_WIDTH-1:0]                 c0_src;
  logic                                 mmio_overflow;

  modport master (
    output mmio_valid, mmio_is_write, mmio_hdr, mmio_data,
    output rsp_valid, rsp_hdr, rsp_data,
    input  rsp_ready,
    input  c0_rspValid, c0_mmioRdValid, c0_mmioWrValid, c0_hdr, c0_data, c0_src,
    input  mmio_overflow
  );

  modport slave (
    input  mmio_valid, mmio_is_write, mmio_hdr, mmio_data,
    input  rsp_valid, rsp_hdr, rsp_data,
    output rsp_ready,
    output c0_rspValid, c0_mmioRdValid, c0_mmioWrValid, c0_hdr, c0_data, c0_src,
    output mmio_overflow
  );
endinterface

// File: rtl/ofs_plat_host_chan_rx_c0_merge.sv
// rtl/ofs_plat_host_chan_rx_c0_merge.sv - merges buffered MMIO requests and N read-response streams onto c0
//
// Purpose: MMIO requests are captured into a small FIFO (they cannot be
// back-pressured) and compete each cycle with N read-response channels for
// one registered c0 output beat. MMIO normally wins; responses are picked
// round-robin starting after the last granted channel.
// Optional feature macro: OFS_PLAT_HOST_CHAN_RX_C0_MERGE_FAIRNESS_EN
//   defined   - after MAX_MMIO_BURST consecutive MMIO grants with a response
//               waiting, one response is forced through.
//   undefined - MMIO has strict priority; MAX_MMIO_BURST is unused.
// Ports:
//   clk    - single clock, posedge
//   reset  - synchronous, active-high
//   bus    - ofs_plat_host_chan_rx_c0_merge_if.slave (MMIO in, responses in,
//            rsp_ready out, registered c0 out, sticky mmio_overflow)
module ofs_plat_host_chan_rx_c0_merge #(
  parameter int N_RSP_CHANNELS = 2,
  parameter int DATA_WIDTH = 512,
  parameter int HDR_WIDTH = 28,
  parameter int MMIO_FIFO_DEPTH = 8,
  parameter int MAX_MMIO_BURST = 4
) (
  input logic clk,
  input logic reset,
  ofs_plat_host_chan_rx_c0_merge_if.slave bus
);
  localparam int SRC_WIDTH = (N_RSP_CHANNELS > 1) ? $clog2(N_RSP_CHANNELS) : 1;
  localparam int PTR_W = $clog2(MMIO_FIFO_DEPTH);
  localparam int ENT_W = 1 + HDR_WIDTH + DATA_WIDTH;

  // MMIO FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [ENT_W-1:0] fifo_mem [MMIO_FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic [ENT_W-1:0] fifo_head;
  logic             enq, drop;

  logic                  any_rsp, hold;
  logic                  mmio_grant, rsp_grant;
  logic                  rr_found, hi_found;
  logic [SRC_WIDTH-1:0]  rr_sel, hi_sel, last_grant;
  logic [HDR_WIDTH-1:0]  sel_hdr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];

  // A full FIFO that pops this cycle still has room for the new request.
  assign enq  = !reset && bus.mmio_valid && (!fifo_full || mmio_grant);
  assign drop = !reset && bus.mmio_valid && fifo_full && !mmio_grant;

  assign any_rsp = |bus.rsp_valid;

`ifdef OFS_PLAT_HOST_CHAN_RX_C0_MERGE_FAIRNESS_EN
  localparam int CNT_W = $clog2(MAX_MMIO_BURST + 1);
  logic [CNT_W-1:0] burst_cnt;

  // Counts MMIO grants that happened while some response was waiting.
  always_ff @(posedge clk) begin
    if (reset || !any_rsp || rsp_grant) begin
      burst_cnt <= '0;
    end else if (mmio_grant && (burst_cnt != CNT_W'(MAX_MMIO_BURST))) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  assign hold = (burst_cnt == CNT_W'(MAX_MMIO_BURST)) && any_rsp;
`else
  logic unused_max_burst;
  assign unused_max_burst = (MAX_MMIO_BURST > 0);
  assign hold = 1'b0;
`endif

  assign mmio_grant = !reset && !fifo_empty && !hold;
  assign rsp_grant  = !reset && !mmio_grant && rr_found;

  // Round robin: the lowest valid channel above last_grant, otherwise wrap
  // to the lowest valid channel overall. The descending scan leaves the
  // lowest matching index in each candidate.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    hi_found = 1'b0;
    hi_sel   = '0;
    for (int c = N_RSP_CHANNELS - 1; c >= 0; c--) begin
      if (bus.rsp_valid[c]) begin
        rr_found = 1'b1;
        rr_sel   = SRC_WIDTH'(c);
        if (c > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_sel   = SRC_WIDTH'(c);
        end
      end
    end
    if (hi_found) begin
      rr_sel = hi_sel;
    end
  end

  always_comb begin
    sel_hdr  = '0;
    sel_data = '0;
    for (int c = 0; c < N_RSP_CHANNELS; c++) begin
      if (SRC_WIDTH'(c) == rr_sel) begin
        sel_hdr  = bus.rsp_hdr[c*HDR_WIDTH +: HDR_WIDTH];
        sel_data = bus.rsp_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.rsp_ready = rsp_grant ? (N_RSP_CHANNELS'(1) << rr_sel) : '0;

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= {bus.mmio_is_write, bus.mmio_hdr, bus.mmio_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      bus.mmio_overflow  <= 1'b0;
      last_grant         <= SRC_WIDTH'(N_RSP_CHANNELS - 1);
      bus.c0_rspValid    <= 1'b0;
      bus.c0_mmioRdValid <= 1'b0;
      bus.c0_mmioWrValid <= 1'b0;
      bus.c0_hdr         <= '0;
      bus.c0_data        <= '0;
      bus.c0_src         <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (mmio_grant) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        bus.mmio_overflow <= 1'b1;
      end
      if (rsp_grant) begin
        last_grant <= rr_sel;
      end

      bus.c0_rspValid    <= rsp_grant;
      bus.c0_mmioRdValid <= mmio_grant && !fifo_head[ENT_W-1];
      bus.c0_mmioWrValid <= mmio_grant && fifo_head[ENT_W-1];

      // With no winner the payload fields keep their last value.
      if (mmio_grant) begin
        bus.c0_hdr  <= fifo_head[DATA_WIDTH +: HDR_WIDTH];
        bus.c0_data <= fifo_head[DATA_WIDTH-1:0];
      end else if (rsp_grant) begin
        bus.c0_hdr  <= sel_hdr;
        bus.c0_data <= sel_data;
        bus.c0_src  <= rr_sel;
      end
    end
  end
endmodule
